mod_74x32_seq: RTL and testbench

- Parametrised, clocked successor to the 2-input OR gate bank models.
- Provides CHANNELS independent 2-input OR channels (optionally NOR) and a configurable pipeline delay.
- The output register has three update modes: transparent, sticky-accumulate (event capture) and hold.
- A saturating counter tracks rising edges of the OR-reduced output. Used where 74x32-style glue logic feeds synchronous capture/flag logic.

---
 rtl/mod_74x32_seq_pkg.sv | 12 +
 rtl/mod_74xx_delay.sv | 28 ++
 rtl/mod_74x32_seq.sv | 107 ++++++++++
 tb/tb_mod_74x32_seq.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/mod_74x32_seq_pkg.sv
// Shared types for the registered 74x32-style OR bank.
// Holds the output update mode encodings used by mod_74x32_seq.
package mod_74x32_seq_pkg;

  typedef enum logic [1:0] {
    MODE_PASS   = 2'b00,
    MODE_STICKY = 2'b01,
    MODE_HOLD   = 2'b10,
    MODE_RSVD   = 2'b11
  } mode_e;

endpackage

// File: rtl/mod_74xx_delay.sv
// WIDTH x STAGES enabled delay line with asynchronous active-low reset.
// Reusable by the registered gate models; requires STAGES >= 1.
module mod_74xx_delay #(
  parameter int WIDTH  = 4,
  parameter int STAGES = 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             en_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] stage_q [STAGES];

  // All stages shift together on enabled edges and hold otherwise
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int s = 0; s < STAGES; s++) stage_q[s] <= '0;
    end else if (en_i) begin
      stage_q[0] <= d_i;
      for (int s = 1; s < STAGES; s++) stage_q[s] <= stage_q[s-1];
    end
  end

  assign q_o = stage_q[STAGES-1];

endmodule

// File: rtl/mod_74x32_seq.sv
// Clocked OR gate bank with pipeline delay, pass/sticky/hold output modes and a rising-edge event counter.
// Optional NOR input selected by defining MOD_74X32_SEQ_NOR_EN.
module mod_74x32_seq
  import mod_74x32_seq_pkg::*;
#(
  parameter int CHANNELS    = 4,
  parameter int PIPE_STAGES = 1,
  parameter int CNT_W       = 8
) (
  input  logic                CLK,
  input  logic                RST_N,
  input  logic [0:CHANNELS-1] A,
  input  logic [0:CHANNELS-1] B,
  input  logic                EN,
  input  logic [1:0]          MODE,
`ifdef MOD_74X32_SEQ_NOR_EN
  input  logic                NOR,
`endif
  input  logic                CLR,
  output logic [0:CHANNELS-1] Y,
  output logic                Y_VALID,
  output logic [CNT_W-1:0]    EVT_CNT
);

  localparam int FILL_W = $clog2(PIPE_STAGES + 1);
  localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(PIPE_STAGES);

  logic [0:CHANNELS-1] gate;
  logic [0:CHANNELS-1] lastStage;
  logic [0:CHANNELS-1] y_q, y_d;
  logic                prevAny_q, prevAny_d;
  logic [CNT_W-1:0]    evtCnt_q, evtCnt_d;
  logic [FILL_W-1:0]   fill_q, fill_d;
  logic                anyY;

`ifdef MOD_74X32_SEQ_NOR_EN
  assign gate = NOR ? ~(A | B) : (A | B);
`else
  assign gate = A | B;
`endif

  // The Y register is the final stage, so the delay line only covers the stages before it
  generate
    if (PIPE_STAGES > 1) begin : gDelay
      mod_74xx_delay #(
        .WIDTH (CHANNELS),
        .STAGES(PIPE_STAGES - 1)
      ) uDelay (
        .clk_i (CLK),
        .rst_ni(RST_N),
        .en_i  (EN),
        .d_i   (gate),
        .q_o   (lastStage)
      );
    end else begin : gDirect
      assign lastStage = gate;
    end
  endgenerate

  assign anyY = |y_q;

  always_comb begin
    y_d       = y_q;
    prevAny_d = anyY;
    evtCnt_d  = evtCnt_q;
    fill_d    = fill_q;

    if (EN && (fill_q != FILL_MAX)) fill_d = fill_q + 1'b1;

    if (CLR) begin
      y_d = '0;
    end else if (EN) begin
      case (mode_e'(MODE))
        MODE_STICKY: y_d = y_q | lastStage;
        MODE_HOLD:   y_d = y_q;
        default:     y_d = lastStage;
      endcase
    end

    // CLR beats a coincident rising edge; the count saturates rather than wrapping
    if (CLR) begin
      evtCnt_d  = '0;
      prevAny_d = 1'b0;
    end else if (anyY && !prevAny_q && (evtCnt_q != '1)) begin
      evtCnt_d = evtCnt_q + 1'b1;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      y_q       <= '0;
      prevAny_q <= 1'b0;
      evtCnt_q  <= '0;
      fill_q    <= '0;
    end else begin
      y_q       <= y_d;
      prevAny_q <= prevAny_d;
      evtCnt_q  <= evtCnt_d;
      fill_q    <= fill_d;
    end
  end

  assign Y       = y_q;
  assign Y_VALID = (fill_q == FILL_MAX);
  assign EVT_CNT = evtCnt_q;

endmodule

// File: tb/tb_mod_74x32_seq.sv
// Scoreboard bench for mod_74x32_seq (CHANNELS=4, PIPE_STAGES=2, CNT_W=4).
// Covers the NOR input too when MOD_74X32_SEQ_NOR_EN is defined.
module tb_mod_74x32_seq;

  logic       CLK;
  logic       RST_N;
  logic [0:3] A, B;
  logic       EN;
  logic [1:0] MODE;
  logic       CLR;
  logic [0:3] Y;
  logic       Y_VALID;
  logic [3:0] EVT_CNT;
`ifdef MOD_74X32_SEQ_NOR_EN
  logic       NOR;
`endif

  mod_74x32_seq #(
    .CHANNELS   (4),
    .PIPE_STAGES(2),
    .CNT_W      (4)
  ) dut (
    .CLK    (CLK),
    .RST_N  (RST_N),
    .A      (A),
    .B      (B),
    .EN     (EN),
    .MODE   (MODE),
`ifdef MOD_74X32_SEQ_NOR_EN
    .NOR    (NOR),
`endif
    .CLR    (CLR),
    .Y      (Y),
    .Y_VALID(Y_VALID),
    .EVT_CNT(EVT_CNT)
  );

  typedef struct packed {
    logic [3:0] y;
    logic       v;
    logic [3:0] c;
  } exp_t;

  exp_t sbQ[$];
  int   checkCount = 0;
  int   failCount  = 0;

  // Reference state for a two-stage pipe: one intermediate stage plus the Y register
  logic [0:3] mD1, mY;
  logic [1:0] mFill;
  logic       mPrev;
  logic [3:0] mCnt;

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checkCount++;
    if (got !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got %0h, required %0h", tag, got, exp);
    end
  endtask

  task automatic modelReset();
    mD1 = '0; mY = '0; mFill = '0; mPrev = 1'b0; mCnt = '0;
    sbQ.delete();
  endtask

  task automatic applyStimulus(input logic [0:3] a, input logic [0:3] b, input logic en,
                               input logic [1:0] mode, input logic clr, input logic nr);
    logic [0:3] g, yNext;
    exp_t e, got;
    A = a; B = b; EN = en; MODE = mode; CLR = clr;
`ifdef MOD_74X32_SEQ_NOR_EN
    NOR = nr;
`endif
    g = nr ? ~(a | b) : (a | b);
    if (clr)        yNext = '0;
    else if (!en)   yNext = mY;
    else if (mode == 2'b01) yNext = mY | mD1;
    else if (mode == 2'b10) yNext = mY;
    else            yNext = mD1;
    if (clr) begin
      mCnt = '0; mPrev = 1'b0;
    end else begin
      if ((|mY) && !mPrev && (mCnt != 4'hF)) mCnt = mCnt + 4'd1;
      mPrev = |mY;
    end
    if (en) begin
      mD1 = g;
      if (mFill != 2'd2) mFill = mFill + 2'd1;
    end
    mY = yNext;
    e.y = mY; e.v = (mFill == 2'd2); e.c = mCnt;
    sbQ.push_back(e);

    @(posedge CLK);
    #1;
    if (sbQ.size() == 0) begin
      checkOutput("scoreboard_empty", 32'd0, 32'd1);
    end else begin
      got = sbQ.pop_front();
      checkOutput("Y", 32'(Y), 32'(got.y));
      checkOutput("Y_VALID", 32'(Y_VALID), 32'(got.v));
      checkOutput("EVT_CNT", 32'(EVT_CNT), 32'(got.c));
    end
  endtask

  initial begin
    RST_N = 1'b0; A = '0; B = '0; EN = 1'b0; MODE = 2'b00; CLR = 1'b0;
`ifdef MOD_74X32_SEQ_NOR_EN
    NOR = 1'b0;
`endif
    modelReset();
    @(posedge CLK);
    #1;
    checkOutput("reset_Y", 32'(Y), 32'd0);
    checkOutput("reset_valid", 32'(Y_VALID), 32'd0);
    checkOutput("reset_cnt", 32'(EVT_CNT), 32'd0);
    RST_N = 1'b1;

    // Transparent fill: data appears after two enabled edges
    applyStimulus(4'b1100, 4'b0011, 1'b1, 2'b00, 1'b0, 1'b0);
    checkOutput("t1_Y_edge1", 32'(Y), 32'd0);
    checkOutput("t1_valid_edge1", 32'(Y_VALID), 32'd0);
    applyStimulus(4'b1100, 4'b0011, 1'b1, 2'b00, 1'b0, 1'b0);
    checkOutput("t1_Y_edge2", 32'(Y), 32'hF);
    checkOutput("t1_valid_edge2", 32'(Y_VALID), 32'd1);
    applyStimulus(4'b0000, 4'b0000, 1'b1, 2'b00, 1'b0, 1'b0);
    applyStimulus(4'b0000, 4'b0000, 1'b1, 2'b00, 1'b0, 1'b0);
    checkOutput("t1_Y_zero", 32'(Y), 32'd0);

    // Sticky accumulation, then clear
    applyStimulus(4'b1000, 4'b0000, 1'b1, 2'b01, 1'b0, 1'b0);
    applyStimulus(4'b0001, 4'b0000, 1'b1, 2'b01, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) applyStimulus(4'b0000, 4'b0000, 1'b1, 2'b01, 1'b0, 1'b0);
    checkOutput("t2_sticky", 32'(Y), 32'h9);
    applyStimulus(4'b0000, 4'b0000, 1'b1, 2'b01, 1'b1, 1'b0);
    checkOutput("t2_clr", 32'(Y), 32'd0);

    // Enable low freezes everything regardless of inputs
    applyStimulus(4'b0110, 4'b0000, 1'b1, 2'b00, 1'b0, 1'b0);
    applyStimulus(4'b0110, 4'b0000, 1'b1, 2'b00, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++)
      applyStimulus(4'($urandom), 4'($urandom), 1'b0, 2'($urandom), 1'b0, 1'b0);
    checkOutput("t3_frozen", 32'(Y), 32'h6);
    applyStimulus(4'b1001, 4'b0000, 1'b1, 2'b00, 1'b0, 1'b0);
    checkOutput("t3_reen_edge1", 32'(Y), 32'h6);
    applyStimulus(4'b1001, 4'b0000, 1'b1, 2'b00, 1'b0, 1'b0);
    checkOutput("t3_reen_edge2", 32'(Y), 32'h9);

    // Hold mode keeps Y while the intermediate stage keeps moving
    applyStimulus(4'b0011, 4'b0000, 1'b1, 2'b10, 1'b0, 1'b0);
    applyStimulus(4'b0011, 4'b0000, 1'b1, 2'b10, 1'b0, 1'b0);
    checkOutput("hold_Y", 32'(Y), 32'h9);
    applyStimulus(4'b0000, 4'b0000, 1'b1, 2'b11, 1'b0, 1'b0);
    checkOutput("rsvd_pass", 32'(Y), 32'h3);

    // Saturation of the event counter
    for (int i = 0; i < 20; i++) begin
      applyStimulus(4'b1000, 4'b0000, 1'b1, 2'b00, 1'b0, 1'b0);
      applyStimulus(4'b1000, 4'b0000, 1'b1, 2'b00, 1'b0, 1'b0);
      applyStimulus(4'b0000, 4'b0000, 1'b1, 2'b00, 1'b0, 1'b0);
      applyStimulus(4'b0000, 4'b0000, 1'b1, 2'b00, 1'b0, 1'b0);
    end
    checkOutput("t4_saturate", 32'(EVT_CNT), 32'd15);
    applyStimulus(4'b1000, 4'b0000, 1'b1, 2'b00, 1'b0, 1'b0);
    applyStimulus(4'b1000, 4'b0000, 1'b1, 2'b00, 1'b0, 1'b0);
    applyStimulus(4'b1000, 4'b0000, 1'b1, 2'b00, 1'b1, 1'b0);
    checkOutput("t4_clr_cnt", 32'(EVT_CNT), 32'd0);
    applyStimulus(4'b1000, 4'b0000, 1'b1, 2'b00, 1'b0, 1'b0);
    applyStimulus(4'b1000, 4'b0000, 1'b1, 2'b00, 1'b0, 1'b0);
    checkOutput("t4_recount", 32'(EVT_CNT), 32'd1);

    // Asynchronous reset between edges
    applyStimulus(4'b1111, 4'b0000, 1'b1, 2'b00, 1'b0, 1'b0);
    #2;
    RST_N = 1'b0;
    #1;
    checkOutput("t5_async_Y", 32'(Y), 32'd0);
    checkOutput("t5_async_valid", 32'(Y_VALID), 32'd0);
    checkOutput("t5_async_cnt", 32'(EVT_CNT), 32'd0);
    modelReset();
    #1;
    RST_N = 1'b1;
    applyStimulus(4'b0101, 4'b0000, 1'b1, 2'b00, 1'b0, 1'b0);
    checkOutput("t5_valid_edge1", 32'(Y_VALID), 32'd0);
    applyStimulus(4'b0101, 4'b0000, 1'b1, 2'b00, 1'b0, 1'b0);
    checkOutput("t5_valid_edge2", 32'(Y_VALID), 32'd1);
    checkOutput("t5_Y", 32'(Y), 32'h5);

`ifdef MOD_74X32_SEQ_NOR_EN
    applyStimulus(4'b1010, 4'b0000, 1'b1, 2'b00, 1'b0, 1'b1);
    applyStimulus(4'b1010, 4'b0000, 1'b1, 2'b00, 1'b0, 1'b1);
    checkOutput("t6_nor", 32'(Y), 32'h5);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
    $finish;
  end

endmodule
